// File: rtl/puf_pkg.sv
// PUF verifier shared types: FSM state encoding and default parameter values.
// Latency: n/a (package).
// Backpressure: n/a (package).
package puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_MEASURE = 3'd2,
    S_SAMPLE  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int DEF_NUM_CHAL    = 8;
  localparam int DEF_WAIT_CYCLES = 64;
  localparam int DEF_THRESH      = 1;

endpackage

// File: rtl/puf_wait_timer.sv
// Measurement window timer: holds the PUF in MEASURE for exactly WAIT_CYCLES cycles.
// Latency: expired rises WAIT_CYCLES-1 enabled cycles after load.
// Backpressure: none; count only advances while en is high.
module puf_wait_timer #(
  parameter int WAIT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Load WAIT_CYCLES-1 so that the cycle seeing cnt==0 is the last MEASURE cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(WAIT_CYCLES - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/puf_verifier.sv
// PUF enroll/verify sequencer: measures NUM_CHAL challenge bits and compares against the enrolled signature.
// Latency: done pulses NUM_CHAL*(WAIT_CYCLES+2)+1 cycles after go is sampled.
// Backpressure: none; go is ignored while busy.
module puf_verifier
  import puf_pkg::*;
#(
  parameter int NUM_CHAL    = DEF_NUM_CHAL,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int THRESH      = DEF_THRESH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            go,
  input  logic                            mode,
  input  logic [NUM_CHAL-1:0]             challenges,
  output logic                            puf_start,
  output logic                            puf_challenge,
  input  logic                            puf_response,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_CHAL-1:0]             signature,
  output logic [$clog2(NUM_CHAL+1)-1:0]   distance,
  output logic                            match,
  output logic                            no_enroll
);

  localparam int DW = $clog2(NUM_CHAL + 1);
  localparam int IW = $clog2(NUM_CHAL);

  state_t              state;
  logic                mode_q;
  logic [NUM_CHAL-1:0] chal_q;
  logic [IW-1:0]       idx;
  logic [NUM_CHAL-1:0] sig_q;
  logic [DW-1:0]       dist_q;
  logic [NUM_CHAL-1:0] enrolled;
  logic                enrolled_valid;
  logic                expired;

  logic [NUM_CHAL-1:0] sig_nxt;
  logic [DW-1:0]       dist_nxt;
  logic [IW-1:0]       idx_nxt;
  logic                last_pair;

  puf_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state == S_START),
    .en      (state == S_MEASURE),
    .expired (expired)
  );

  // Fold the current response into the running signature and distance
  always_comb begin
    sig_nxt      = sig_q;
    sig_nxt[idx] = puf_response;
    dist_nxt     = dist_q;
    if (mode_q && (puf_response != enrolled[idx])) begin
      dist_nxt = dist_q + DW'(1);
    end
    idx_nxt   = idx + IW'(1);
    last_pair = (idx == IW'(NUM_CHAL - 1));
  end

  // Run sequencer with registered PUF controls and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      mode_q         <= 1'b0;
      chal_q         <= '0;
      idx            <= '0;
      sig_q          <= '0;
      dist_q         <= '0;
      enrolled       <= '0;
      enrolled_valid <= 1'b0;
      puf_start      <= 1'b0;
      puf_challenge  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      signature      <= '0;
      distance       <= '0;
      match          <= 1'b0;
      no_enroll      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            mode_q        <= mode;
            chal_q        <= challenges;
            idx           <= '0;
            sig_q         <= '0;
            dist_q        <= '0;
            busy          <= 1'b1;
            puf_start     <= 1'b1;
            puf_challenge <= challenges[0];
            state         <= S_START;
          end
        end
        S_START: begin
          puf_start <= 1'b0;
          state     <= S_MEASURE;
        end
        S_MEASURE: begin
          if (expired) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          sig_q  <= sig_nxt;
          dist_q <= dist_nxt;
          if (last_pair) begin
            done      <= 1'b1;
            signature <= sig_nxt;
            state     <= S_DONE;
            if (!mode_q) begin
              enrolled       <= sig_nxt;
              enrolled_valid <= 1'b1;
              distance       <= '0;
              match          <= 1'b0;
              no_enroll      <= 1'b0;
            end else if (enrolled_valid) begin
              distance  <= dist_nxt;
              match     <= (32'(dist_nxt) <= THRESH);
              no_enroll <= 1'b0;
            end else begin
              distance  <= '0;
              match     <= 1'b0;
              no_enroll <= 1'b1;
            end
          end else begin
            idx           <= idx_nxt;
            puf_start     <= 1'b1;
            puf_challenge <= chal_q[idx_nxt];
            state         <= S_START;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_verifier.sv
// Directed bench for puf_verifier with a table-driven PUF response model.
// Latency: run latency checked against NUM_CHAL*(WAIT_CYCLES+2)+1 = 21.
// Backpressure: n/a.
module tb_puf_verifier;

  localparam int NC = 4;
  localparam int WC = 3;
  localparam int TH = 1;
  localparam int RUN_LAT = NC * (WC + 2) + 1;

  logic          clk;
  logic          rst_n;
  logic          go;
  logic          mode;
  logic [NC-1:0] challenges;
  logic          puf_start;
  logic          puf_challenge;
  logic          puf_response;
  logic          busy;
  logic          done;
  logic [NC-1:0] signature;
  logic [$clog2(NC+1)-1:0] distance;
  logic          match;
  logic          no_enroll;

  int n_checks;
  int n_fail;

  puf_verifier #(.NUM_CHAL(NC), .WAIT_CYCLES(WC), .THRESH(TH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .go            (go),
    .mode          (mode),
    .challenges    (challenges),
    .puf_start     (puf_start),
    .puf_challenge (puf_challenge),
    .puf_response  (puf_response),
    .busy          (busy),
    .done          (done),
    .signature     (signature),
    .distance      (distance),
    .match         (match),
    .no_enroll     (no_enroll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Launch one run; the PUF model answers pair i with resp[i].
  // Cycle 1 is the cycle after the edge that samples go.
  task automatic do_run(input logic m, input logic [NC-1:0] ch, input logic [NC-1:0] resp,
                        input bit go_mid, output int lat, output logic [NC-1:0] chal_seq,
                        output int done_cnt);
    int pair;
    lat = 0;
    done_cnt = 0;
    chal_seq = '0;
    pair = -1;
    @(negedge clk);
    go = 1'b1;
    mode = m;
    challenges = ch;
    @(posedge clk);
    #1;
    go = 1'b0;
    mode = ~m;
    challenges = ~ch;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (puf_start) begin
        pair++;
        if (pair >= 0 && pair < NC) begin
          chal_seq[pair] = puf_challenge;
          puf_response = resp[pair];
        end
      end
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = cyc;
      end
      if (go_mid && cyc == 3) begin
        go = 1'b1;
        mode = 1'b0;
      end
      if (go_mid && cyc == 4) go = 1'b0;
    end
  endtask

  int            lat;
  int            dcnt;
  logic [NC-1:0] cseq;

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    go = 1'b0;
    mode = 1'b0;
    challenges = '0;
    puf_response = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(puf_start), 0);
    check("rst_chal", 32'(puf_challenge), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sig", 32'(signature), 0);
    check("rst_dist", 32'(distance), 0);
    check("rst_match", 32'(match), 0);
    check("rst_noenr", 32'(no_enroll), 0);
    rst_n = 1'b1;

    // Enroll: responses 1,0,1,1 -> signature 4'b1101
    do_run(1'b0, 4'b1010, 4'b1101, 1'b0, lat, cseq, dcnt);
    check("enr_lat", 32'(lat), RUN_LAT);
    check("enr_dones", 32'(dcnt), 1);
    check("enr_sig", 32'(signature), 32'h0000000d);
    check("enr_chalseq", 32'(cseq), 32'h0000000a);
    check("enr_dist", 32'(distance), 0);
    check("enr_match", 32'(match), 0);
    check("enr_noenr", 32'(no_enroll), 0);
    check("enr_busy", 32'(busy), 0);

    // Verify with identical responses
    do_run(1'b1, 4'b1010, 4'b1101, 1'b0, lat, cseq, dcnt);
    check("vm_sig", 32'(signature), 32'h0000000d);
    check("vm_dist", 32'(distance), 0);
    check("vm_match", 32'(match), 1);
    check("vm_noenr", 32'(no_enroll), 0);

    // Verify with responses 0,1,1,1 -> two bits differ
    do_run(1'b1, 4'b0110, 4'b1110, 1'b0, lat, cseq, dcnt);
    check("vx_sig", 32'(signature), 32'h0000000e);
    check("vx_dist", 32'(distance), 2);
    check("vx_match", 32'(match), 0);
    check("vx_chalseq", 32'(cseq), 32'h00000006);

    // Verify at the threshold: one bit differs
    do_run(1'b1, 4'b0011, 4'b1100, 1'b0, lat, cseq, dcnt);
    check("vt_dist", 32'(distance), 1);
    check("vt_match", 32'(match), 1);

    // go pulsed during MEASURE must be ignored; enrollment still intact
    do_run(1'b1, 4'b1010, 4'b1101, 1'b1, lat, cseq, dcnt);
    check("gm_lat", 32'(lat), RUN_LAT);
    check("gm_dones", 32'(dcnt), 1);
    check("gm_dist", 32'(distance), 0);
    check("gm_match", 32'(match), 1);

    // Reset mid-run: abort, no done, enrollment cleared
    @(negedge clk);
    go = 1'b1;
    mode = 1'b0;
    challenges = 4'b0101;
    @(negedge clk);
    go = 1'b0;
    repeat (5) @(negedge clk);
    check("mr_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_busy", 32'(busy), 0);
    check("mr_start", 32'(puf_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("mr_sig", 32'(signature), 0);
    check("mr_match", 32'(match), 0);
    check("mr_dist", 32'(distance), 0);
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("mr_nodone", 32'(dcnt), 0);

    // Verify with nothing enrolled
    do_run(1'b1, 4'b1111, 4'b0101, 1'b0, lat, cseq, dcnt);
    check("ne_lat", 32'(lat), RUN_LAT);
    check("ne_noenr", 32'(no_enroll), 1);
    check("ne_match", 32'(match), 0);
    check("ne_dist", 32'(distance), 0);
    check("ne_sig", 32'(signature), 32'h00000005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_verifier.md
PUF_VERIFIER -- requirements
Module: puf_verifier

Interface
REQ-001 SHALL have parameter NUM_CHAL, default 8: challenge/response pairs per run (2..32).
REQ-002 SHALL have parameter WAIT_CYCLES, default 64: clk cycles PUF measurement is held per pair (>=1).
REQ-003 SHALL have parameter THRESH, default 1: max Hamming distance accepted as match.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port go  in  1  run request, sampled only in IDLE.
REQ-007 SHALL have port mode  in  1  0=enroll, 1=verify; sampled with go.
REQ-008 SHALL have port challenges  in  NUM_CHAL  challenge bit per pair; latched with go.
REQ-009 SHALL have port puf_start  out  1  clears/starts PUF counters and timer.
REQ-010 SHALL have port puf_challenge  out  1  challenge bit driven to the PUF mux select.
REQ-011 SHALL have port puf_response  in  1  PUF counter-comparison result.
REQ-012 SHALL have port busy  out  1  high in every state except IDLE.
REQ-013 SHALL have port done  out  1  one-cycle pulse on run completion.
REQ-014 SHALL have port signature  out  NUM_CHAL  responses of last run, bit i = pair i.
REQ-015 SHALL have port distance  out  $clog2(NUM_CHAL+1)  Hamming distance vs enrolled signature.
REQ-016 SHALL have port match  out  1  verify passed (distance <= THRESH).
REQ-017 SHALL have port no_enroll  out  1  verify requested with no enrollment stored.

Function
REQ-018 SHALL implement FSM states IDLE, START, MEASURE, SAMPLE, DONE.
REQ-019 IDLE: go=1 -> latch mode and challenges, idx=0, clear running distance -> START; go=0 -> stay.
REQ-020 START (1 cycle): puf_start=1, puf_challenge=challenges[idx] -> MEASURE.
REQ-021 MEASURE (exactly WAIT_CYCLES cycles): puf_start=0, puf_challenge held at challenges[idx] -> SAMPLE.
REQ-022 SAMPLE (1 cycle): sig[idx]<=puf_response; in verify mode, distance+1 if puf_response != enrolled[idx]; idx==NUM_CHAL-1 -> DONE, else idx+1 -> START.
REQ-023 DONE (1 cycle): done=1; signature, distance, match, no_enroll updated on DONE entry; -> IDLE.
REQ-024 Enroll run: enrolled register <= sig, enrolled_valid <= 1; distance=0, match=0, no_enroll=0.
REQ-025 Verify run with enrolled_valid=1: match = (distance <= THRESH), no_enroll=0; enrolled register unchanged.
REQ-026 Verify run with enrolled_valid=0: all pairs still measured; no_enroll=1, match=0, distance=0.
REQ-027 Run latency: go sampled at edge k -> done high during cycle k+NUM_CHAL*(WAIT_CYCLES+2)+1.
REQ-028 go while busy SHALL be ignored; mode/challenges changes mid-run SHALL have no effect.
REQ-029 Results SHALL hold their values until the next DONE.
REQ-030 Back-to-back: go high in the first IDLE cycle after DONE SHALL start a new run.
REQ-031 distance counter SHALL not wrap (width covers NUM_CHAL).

Reset
REQ-032 rst_n=0 at an edge: state=IDLE; puf_start, puf_challenge, busy, done, match, no_enroll = 0; signature, distance, idx = 0.
REQ-033 Reset SHALL clear enrolled register and enrolled_valid.
REQ-034 Reset mid-run SHALL abort with no done pulse; busy=0 and puf_start=0 in the next cycle.

Structure
REQ-035 Package puf_pkg SHALL hold the FSM state enum and default NUM_CHAL/WAIT_CYCLES/THRESH constants.
REQ-036 One sub-module, puf_wait_timer (load/count/expire for MEASURE), SHALL be used; all else inline.

Verification (NUM_CHAL=4, WAIT_CYCLES=3, THRESH=1, bench PUF model)
REQ-037 Reset: hold rst_n=0 two cycles mid-run -> all outputs 0, no done pulse.
REQ-038 Enroll: go, mode=0, challenges=4'b1010, responses 1,0,1,1 -> done 21 cycles after go, signature=4'b1101, puf_challenge sequence 0,1,0,1.
REQ-039 Verify match: same responses -> distance=0, match=1, no_enroll=0.
REQ-040 Verify mismatch: responses 0,1,1,1 -> signature=4'b1110, distance=2, match=0.
REQ-041 No enrollment after reset: verify run -> no_enroll=1, match=0, distance=0.
REQ-042 go pulsed during MEASURE -> ignored; single done, total latency still 21 cycles.
